// File: rtl/uart_rx.sv
// 8-bit LSB-first UART receiver with two-flop input sync and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int BAUD = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       rcv_o,
    output logic       ferr_o,
    output logic       perr_o,
    output logic       busy_o
);

    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] LAST = CW'(BAUD - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e        state_q;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q;
    logic          rcv_q, ferr_q, busy_q;
    logic          cnt_last;

    assign cnt_d    = cnt_q + CW'(1);
    assign cnt_last = (cnt_q == LAST);
    // Right shift: first received bit ends up in bit 0 after eight samples.
    assign shift_d  = {rx_s_q, shift_q[7:1]};

`ifdef UART_RX_PARITY_EN
    logic par_q, perr_q;
    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            rcv_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            rcv_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            cnt_q     <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s_q;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            rcv_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= ^{shift_q, par_q};
`endif
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Stop low: report once, then wait out the low line.
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o = data_q;
    assign rcv_o  = rcv_q;
    assign ferr_o = ferr_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus random frames for uart_rx at 8 clk/bit, checked against a
// frame-level model (expected byte, parity flag and start-edge time per frame).
module tb_uart_rx;
    localparam int BAUD = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // 2 sync flops + half a bit + the remaining bits up to the stop sample.
    localparam int LAT_NOM = 2 + BAUD / 2 + (FRAME_BITS - 1) * BAUD;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       rcv_o, ferr_o, perr_o, busy_o;

    always #5 clk = ~clk;

    uart_rx #(.BAUD(BAUD)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .rx_i  (rx_i),
        .data_o(data_o),
        .rcv_o (rcv_o),
        .ferr_o(ferr_o),
        .perr_o(perr_o),
        .busy_o(busy_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] d; logic perr; logic busy; } rcv_ev_t;
    typedef struct { int start; logic [7:0] d; logic perr; } exp_t;
    rcv_ev_t ev_q[$];
    int      ferr_q[$];
    int      stray_perr = 0;
    exp_t    exp_q[$];

    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        if (rcv_o) ev_q.push_back('{cyc, data_o, perr_o, busy_o});
        if (ferr_o) ferr_q.push_back(cyc);
        if (perr_o && !rcv_o) stray_perr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (BAUD) @(negedge clk);
    endtask

    // Even parity: a correct parity bit is ^b; perr expected when it differs.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        int s;
        s = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
        if (stop) exp_q.push_back('{s, b, (^b) ^ par});
`else
        if (stop) exp_q.push_back('{s, b, 1'b0});
`endif
        send_bit(stop);
    endtask

    task automatic check_rcv(input string tag);
        exp_t    e;
        rcv_ev_t v;
        int      lat;
        repeat (3) @(negedge clk);
        chk({tag, ".count"}, ev_q.size(), exp_q.size());
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            v = ev_q.pop_front();
            lat = v.cyc - e.start;
            chk({tag, ".data"}, v.d, e.d);
            chk({tag, ".perr"}, v.perr, e.perr);
            chk({tag, ".busy_at_rcv"}, v.busy, 1'b0);
            chk({tag, ".lat_in_window"}, 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
        end
        ev_q.delete();
        exp_q.delete();
        chk({tag, ".no_ferr"}, ferr_q.size(), 0);
        ferr_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         gap;

        rstn = 1'b0;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.data", data_o, 8'h00);
        chk("rst.rcv", rcv_o, 1'b0);
        chk("rst.ferr", ferr_o, 1'b0);
        chk("rst.perr", perr_o, 1'b0);
        chk("rst.busy", busy_o, 1'b0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Plain frame
        send_frame(8'h55, 1'b0, 1'b1);
        check_rcv("t1");
        chk("t1.data_out", data_o, 8'h55);

        // Glitch shorter than half a bit is a false start
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2.busy", busy_o, 1'b0);
        repeat (20) @(negedge clk);
        chk("t2.no_rcv", ev_q.size(), 0);
        chk("t2.no_ferr", ferr_q.size(), 0);

        // Framing error with the line held low afterwards
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b8(8'h3C, i));
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rx_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("t3.busy_low", busy_o, 1'b1);
        chk("t3.ferr_count", ferr_q.size(), 1);
        chk("t3.no_rcv", ev_q.size(), 0);
        chk("t3.data_held", data_o, 8'h55);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3.busy_release", busy_o, 1'b0);
        chk("t3.ferr_once", ferr_q.size(), 1);
        ferr_q.delete();
        repeat (16) @(negedge clk);

        // Back-to-back frames
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        check_rcv("t4");
        chk("t4.data_out", data_o, 8'h0F);

        // Reset during bit 4 of a frame; the sender abandons that frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b8(8'h5A, i));
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t5.rst_data", data_o, 8'h00);
        chk("t5.rst_busy", busy_o, 1'b0);
        chk("t5.rst_rcv", rcv_o, 1'b0);
        repeat (30) @(negedge clk);
        chk("t5.no_pulse_rcv", ev_q.size(), 0);
        chk("t5.no_pulse_ferr", ferr_q.size(), 0);
        send_frame(8'h81, 1'b0, 1'b1);
        check_rcv("t5");
        chk("t5.data_out", data_o, 8'h81);

        // Random bytes with random idle gaps (including none)
        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 2);
            send_frame(b, ^b, 1'b1);
            rx_i = 1'b1;
            repeat (gap * BAUD) @(negedge clk);
        end
        check_rcv("rand");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        check_rcv("par_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        check_rcv("par_good");
`endif

        chk("stray_perr", stray_perr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic b8(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
